// File: rtl/mig_app_responder_if.sv
// MIG DDR3 user (app) interface bundle: the initiator drives the master modport,
// the memory responder sits on the slave modport.
interface mig_app_responder_if #(
    parameter int DATA_WIDTH   = 128,
    parameter int ADDRESS_SIZE = 28
);
    logic [ADDRESS_SIZE-1:0] app_addr;
    logic [2:0]              app_cmd;
    logic                    app_en;
    logic                    app_rdy;
    logic [DATA_WIDTH-1:0]   app_wdf_data;
    logic [DATA_WIDTH/8-1:0] app_wdf_mask;
    logic                    app_wdf_wren;
    logic                    app_wdf_end;
    logic                    app_wdf_rdy;
    logic [DATA_WIDTH-1:0]   app_rd_data;
    logic                    app_rd_data_valid;
    logic                    app_rd_data_end;
    logic                    init_calib_complete;
    logic                    protocol_error;

    modport master (
        output app_addr, app_cmd, app_en,
        output app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end,
        input  app_rdy, app_wdf_rdy,
        input  app_rd_data, app_rd_data_valid, app_rd_data_end,
        input  init_calib_complete, protocol_error
    );

    modport slave (
        input  app_addr, app_cmd, app_en,
        input  app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end,
        output app_rdy, app_wdf_rdy,
        output app_rd_data, app_rd_data_valid, app_rd_data_end,
        output init_calib_complete, protocol_error
    );
endinterface

// File: rtl/mig_app_responder.sv
// Burst-organised on-chip memory answering MIG app-interface commands with calibration delay
// and fixed read latency. Define MIG_RESPONDER_BACKPRESSURE_EN for LFSR-driven ready stalls.
module mig_app_responder #(
    parameter int DATA_WIDTH   = 128,
    parameter int ADDRESS_SIZE = 28,
    parameter int BURST_LEN    = 8,
    parameter int DEPTH        = 1024,
    parameter int READ_LATENCY = 4,
    parameter int CALIB_CYCLES = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    mig_app_responder_if.slave  app
);
    localparam int NUM_BYTES  = DATA_WIDTH / 8;
    localparam int NUM_BURSTS = DEPTH / BURST_LEN;
    localparam int INDEX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int BEAT_SHIFT = $clog2(BURST_LEN);
    localparam int BEAT_W     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int BURST_W    = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;
    localparam int CALIB_W    = $clog2(CALIB_CYCLES + 1);
    localparam int LAT_W      = $clog2(READ_LATENCY + 1);

    localparam logic [2:0]        CMD_READ  = 3'b001;
    localparam logic [2:0]        CMD_WRITE = 3'b010;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    typedef enum logic [2:0] {
        S_CALIB,
        S_IDLE,
        S_WRITE_DATA,
        S_READ_WAIT,
        S_READ_DATA
    } state_t;

    state_t               state_reg, state_next;
    logic [CALIB_W-1:0]   calib_cnt_reg, calib_cnt_next;
    logic [LAT_W-1:0]     lat_cnt_reg, lat_cnt_next;
    logic [BEAT_W-1:0]    beat_reg, beat_next;
    logic [BURST_W-1:0]   burst_reg, burst_next;
    logic                 app_rdy_reg;
    logic                 wdf_rdy_reg;
    logic                 init_reg;
    logic                 error_reg;
    logic                 rd_valid_reg;
    logic                 rd_end_reg;

    logic                 cmd_accept;
    logic                 beat_accept;
    logic                 error_set;
    logic                 mem_wr_en;
    logic                 wr_fire;
    logic                 rd_load;
    logic [BEAT_W-1:0]    rd_load_beat;
    logic [BURST_W-1:0]   rd_load_burst;
    logic [BURST_W-1:0]   cmd_burst;
    logic [INDEX_W-1:0]   wr_index;
    logic [INDEX_W-1:0]   rd_index;
    logic                 stall_next;

    function automatic logic [INDEX_W-1:0] make_index(input logic [BURST_W-1:0] burst,
                                                      input logic [BEAT_W-1:0]  beat);
        return (INDEX_W'(burst) << BEAT_SHIFT) | INDEX_W'(beat);
    endfunction

    // Address bits [2:0] select nothing; the burst slot wraps modulo the number of bursts held.
    assign cmd_burst = BURST_W'((app.app_addr >> 3) % ADDRESS_SIZE'(NUM_BURSTS));
    assign wr_index  = make_index(burst_reg, beat_reg);
    assign rd_index  = make_index(rd_load_burst, rd_load_beat);
    assign wr_fire   = mem_wr_en && rst_n;

`ifdef MIG_RESPONDER_BACKPRESSURE_EN
    logic [15:0] lfsr_reg;
    logic [15:0] lfsr_next;

    // Fibonacci form of x^16+x^14+x^13+x^11+1; the ready registers look one step ahead
    // so a ready output drops in exactly the cycle the running LFSR shows bit0=1.
    assign lfsr_next  = {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
    assign stall_next = lfsr_next[0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr_reg <= 16'hACE1;
        end else begin
            lfsr_reg <= lfsr_next;
        end
    end
`else
    assign stall_next = 1'b0;
`endif

    always_comb begin
        state_next     = state_reg;
        calib_cnt_next = calib_cnt_reg;
        lat_cnt_next   = lat_cnt_reg;
        beat_next      = beat_reg;
        burst_next     = burst_reg;
        mem_wr_en      = 1'b0;
        rd_load        = 1'b0;
        rd_load_beat   = beat_reg;
        rd_load_burst  = burst_reg;
        error_set      = 1'b0;
        cmd_accept     = app.app_en && app_rdy_reg;
        beat_accept    = app.app_wdf_wren && wdf_rdy_reg;

        if (app.app_wdf_wren && (state_reg != S_WRITE_DATA)) begin
            error_set = 1'b1;
        end

        case (state_reg)
            S_CALIB: begin
                if (calib_cnt_reg == CALIB_W'(CALIB_CYCLES - 1)) begin
                    state_next = S_IDLE;
                end else begin
                    calib_cnt_next = calib_cnt_reg + 1'b1;
                end
            end

            S_IDLE: begin
                if (cmd_accept) begin
                    burst_next = cmd_burst;
                    beat_next  = '0;
                    case (app.app_cmd)
                        CMD_READ: begin
                            if (READ_LATENCY == 1) begin
                                rd_load       = 1'b1;
                                rd_load_beat  = '0;
                                rd_load_burst = cmd_burst;
                                beat_next     = BEAT_W'(1);
                                state_next    = S_READ_DATA;
                            end else begin
                                lat_cnt_next = '0;
                                state_next   = S_READ_WAIT;
                            end
                        end
                        CMD_WRITE: state_next = S_WRITE_DATA;
                        default:   error_set  = 1'b1;
                    endcase
                end
            end

            S_WRITE_DATA: begin
                if (beat_accept) begin
                    mem_wr_en = 1'b1;
                    if (app.app_wdf_end != (beat_reg == LAST_BEAT)) begin
                        error_set = 1'b1;
                    end
                    beat_next = beat_reg + 1'b1;
                    if (beat_reg == LAST_BEAT) begin
                        state_next = S_IDLE;
                    end
                end
            end

            // The first beat is fetched on the last wait edge so it is visible at exactly READ_LATENCY.
            S_READ_WAIT: begin
                if (lat_cnt_reg == LAT_W'(READ_LATENCY - 2)) begin
                    rd_load      = 1'b1;
                    rd_load_beat = '0;
                    beat_next    = BEAT_W'(1);
                    state_next   = S_READ_DATA;
                end else begin
                    lat_cnt_next = lat_cnt_reg + 1'b1;
                end
            end

            S_READ_DATA: begin
                if (rd_end_reg) begin
                    state_next = S_IDLE;
                end else begin
                    rd_load      = 1'b1;
                    rd_load_beat = beat_reg;
                    beat_next    = beat_reg + 1'b1;
                end
            end

            default: state_next = S_CALIB;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= S_CALIB;
            calib_cnt_reg <= '0;
            lat_cnt_reg   <= '0;
            beat_reg      <= '0;
            burst_reg     <= '0;
            app_rdy_reg   <= 1'b0;
            wdf_rdy_reg   <= 1'b0;
            init_reg      <= 1'b0;
            error_reg     <= 1'b0;
            rd_valid_reg  <= 1'b0;
            rd_end_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            calib_cnt_reg <= calib_cnt_next;
            lat_cnt_reg   <= lat_cnt_next;
            beat_reg      <= beat_next;
            burst_reg     <= burst_next;
            app_rdy_reg   <= (state_next == S_IDLE) && !stall_next;
            wdf_rdy_reg   <= (state_next == S_WRITE_DATA) && !stall_next;
            init_reg      <= (state_next != S_CALIB);
            error_reg     <= error_reg || error_set;
            rd_valid_reg  <= rd_load;
            rd_end_reg    <= rd_load && (rd_load_beat == LAST_BEAT);
        end
    end

    // One byte lane per RAM so the write mask maps onto independent lane write enables.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_BYTES; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];
            logic [7:0] lane_q;

            always_ff @(posedge clk) begin
                if (wr_fire && !app.app_wdf_mask[gi]) begin
                    lane_mem[wr_index] <= app.app_wdf_data[gi*8 +: 8];
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    lane_q <= '0;
                end else if (rd_load) begin
                    lane_q <= lane_mem[rd_index];
                end
            end

            assign app.app_rd_data[gi*8 +: 8] = lane_q;
        end
    endgenerate

    assign app.app_rdy             = app_rdy_reg;
    assign app.app_wdf_rdy         = wdf_rdy_reg;
    assign app.app_rd_data_valid   = rd_valid_reg;
    assign app.app_rd_data_end     = rd_end_reg;
    assign app.init_calib_complete = init_reg;
    assign app.protocol_error      = error_reg;

endmodule

// File: tb/tb_mig_app_responder.sv
// Self-checking bench for mig_app_responder: directed scenarios plus random bursts checked
// against a flat array model of the burst-addressed storage.
module tb_mig_app_responder;
    localparam int DW      = 128;
    localparam int AS      = 28;
    localparam int BL      = 8;
    localparam int DEPTH   = 1024;
    localparam int RL      = 4;
    localparam int CALIB   = 64;
    localparam int NB      = DW / 8;
    localparam int NBURST  = DEPTH / BL;
    localparam int TIMEOUT = 200;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    logic [DW-1:0] model_mem [DEPTH];
    logic [DW-1:0] wr_data [BL];
    logic [NB-1:0] wr_mask [BL];

    mig_app_responder_if #(.DATA_WIDTH(DW), .ADDRESS_SIZE(AS)) app ();

    mig_app_responder #(
        .DATA_WIDTH  (DW),
        .ADDRESS_SIZE(AS),
        .BURST_LEN   (BL),
        .DEPTH       (DEPTH),
        .READ_LATENCY(RL),
        .CALIB_CYCLES(CALIB)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .app  (app)
    );

    always #5 clk = ~clk;

    // Storage slot from the address rule: burst number modulo slots, then beat offset.
    function automatic int model_index(input logic [AS-1:0] addr, input int beat);
        return int'((addr >> 3) % NBURST) * BL + beat;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        app.app_addr     = '0;
        app.app_cmd      = 3'b000;
        app.app_en       = 1'b0;
        app.app_wdf_data = '0;
        app.app_wdf_mask = '0;
        app.app_wdf_wren = 1'b0;
        app.app_wdf_end  = 1'b0;
    endtask

    task automatic issue_cmd(input logic [AS-1:0] addr, input logic [2:0] cmd, output bit ok);
        bit rdy;
        int n;
        n  = 0;
        ok = 1'b0;
        app.app_addr = addr;
        app.app_cmd  = cmd;
        app.app_en   = 1'b1;
        while (!ok && n < TIMEOUT) begin
            rdy = app.app_rdy;
            step();
            if (rdy) ok = 1'b1;
            n++;
        end
        app.app_en = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL cmd_accept addr=%h cmd=%b: app_rdy never high in %0d cycles, required acceptance", addr, cmd, TIMEOUT);
        end
    endtask

    task automatic do_reset();
        int n;
        n = 0;
        idle_inputs();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        while (app.init_calib_complete !== 1'b1 && n < CALIB + 10) begin
            step();
            n++;
        end
        checks++;
        if (n != CALIB) begin
            errors++;
            $display("FAIL calib_length: calibration took %0d cycles, required %0d", n, CALIB);
        end
    endtask

    task automatic write_burst(input logic [AS-1:0] addr, input int bad_end);
        bit ok;
        bit rdy;
        int n;
        int total;
        issue_cmd(addr, 3'b010, ok);
        if (!ok) return;
`ifndef MIG_RESPONDER_BACKPRESSURE_EN
        checks++;
        if (app.app_wdf_rdy !== 1'b1) begin
            errors++;
            $display("FAIL wdf_rdy_after_cmd addr=%h: app_wdf_rdy=%b, required 1", addr, app.app_wdf_rdy);
        end
`endif
        total = 0;
        for (int b = 0; b < BL; b++) begin
            app.app_wdf_data = wr_data[b];
            app.app_wdf_mask = wr_mask[b];
            app.app_wdf_end  = (b == BL - 1) || (b == bad_end);
            app.app_wdf_wren = 1'b1;
            ok = 1'b0;
            n  = 0;
            while (!ok && n < TIMEOUT) begin
                rdy = app.app_wdf_rdy;
                step();
                if (rdy) ok = 1'b1;
                n++;
            end
            total += n;
            app.app_wdf_wren = 1'b0;
            app.app_wdf_end  = 1'b0;
            if (!ok) begin
                checks++;
                errors++;
                $display("FAIL wdf_accept addr=%h beat=%0d: app_wdf_rdy never high, required acceptance", addr, b);
                return;
            end
            for (int k = 0; k < NB; k++) begin
                if (!wr_mask[b][k]) model_mem[model_index(addr, b)][k*8 +: 8] = wr_data[b][k*8 +: 8];
            end
            checks++;
            if (b < BL - 1) begin
                if (app.app_rdy !== 1'b0) begin
                    errors++;
                    $display("FAIL app_rdy_mid_write addr=%h beat=%0d: app_rdy=%b, required 0", addr, b, app.app_rdy);
                end
            end else if (app.app_wdf_rdy !== 1'b0) begin
                errors++;
                $display("FAIL wdf_rdy_after_burst addr=%h: app_wdf_rdy=%b, required 0", addr, app.app_wdf_rdy);
            end
        end
`ifndef MIG_RESPONDER_BACKPRESSURE_EN
        checks++;
        if (app.app_rdy !== 1'b1) begin
            errors++;
            $display("FAIL app_rdy_after_write addr=%h: app_rdy=%b, required 1", addr, app.app_rdy);
        end
        checks++;
        if (total != BL) begin
            errors++;
            $display("FAIL write_throughput addr=%h: %0d cycles for burst, required %0d", addr, total, BL);
        end
`endif
        $display("write addr=%h beat0=%h mask0=%h bad_end=%0d", addr, wr_data[0], wr_mask[0], bad_end);
    endtask

    task automatic read_burst(input logic [AS-1:0] addr);
        bit ok;
        int beat;
        int k;
        int first;
        logic [DW-1:0] exp;
        issue_cmd(addr, 3'b001, ok);
        if (!ok) return;
        beat  = 0;
        k     = 0;
        first = -1;
        while (beat < BL && k < TIMEOUT) begin
            if (app.app_rd_data_valid === 1'b1) begin
                if (first < 0) first = k;
                exp = model_mem[model_index(addr, beat)];
                checks++;
                if (app.app_rd_data !== exp) begin
                    errors++;
                    $display("FAIL rd_data addr=%h beat=%0d: got %h, required %h", addr, beat, app.app_rd_data, exp);
                end
                checks++;
                if (app.app_rd_data_end !== (beat == BL - 1)) begin
                    errors++;
                    $display("FAIL rd_end addr=%h beat=%0d: got %b, required %b", addr, beat, app.app_rd_data_end, beat == BL - 1);
                end
                checks++;
                if (k - first != beat) begin
                    errors++;
                    $display("FAIL rd_gap addr=%h beat=%0d: arrived %0d cycles after first, required %0d", addr, beat, k - first, beat);
                end
                beat++;
            end
            if (beat < BL) begin
                step();
                k++;
            end
        end
        if (beat < BL) begin
            checks++;
            errors++;
            $display("FAIL rd_timeout addr=%h: received %0d beats, required %0d", addr, beat, BL);
            return;
        end
        checks++;
        if (first + 1 != RL) begin
            errors++;
            $display("FAIL rd_latency addr=%h: first beat %0d cycles after accept, required %0d", addr, first + 1, RL);
        end
        step();
        checks++;
        if (app.app_rd_data_valid !== 1'b0) begin
            errors++;
            $display("FAIL rd_valid_after_burst addr=%h: valid=%b, required 0", addr, app.app_rd_data_valid);
        end
`ifndef MIG_RESPONDER_BACKPRESSURE_EN
        checks++;
        if (app.app_rdy !== 1'b1) begin
            errors++;
            $display("FAIL app_rdy_after_read addr=%h: app_rdy=%b, required 1", addr, app.app_rdy);
        end
`endif
        $display("read  addr=%h beat0=%h", addr, model_mem[model_index(addr, 0)]);
    endtask

    task automatic test_reset();
        logic exp;
        idle_inputs();
        rst_n = 1'b0;
        repeat (3) step();
        checks++;
        if (app.app_rdy !== 1'b0 || app.app_wdf_rdy !== 1'b0) begin
            errors++;
            $display("FAIL reset_rdy: app_rdy=%b app_wdf_rdy=%b, required 0 0", app.app_rdy, app.app_wdf_rdy);
        end
        checks++;
        if (app.app_rd_data !== '0 || app.app_rd_data_valid !== 1'b0 || app.app_rd_data_end !== 1'b0) begin
            errors++;
            $display("FAIL reset_rd: data=%h valid=%b end=%b, required 0 0 0", app.app_rd_data, app.app_rd_data_valid, app.app_rd_data_end);
        end
        checks++;
        if (app.init_calib_complete !== 1'b0 || app.protocol_error !== 1'b0) begin
            errors++;
            $display("FAIL reset_status: init=%b perr=%b, required 0 0", app.init_calib_complete, app.protocol_error);
        end
        rst_n = 1'b1;
        for (int i = 1; i <= CALIB; i++) begin
            step();
            exp = (i == CALIB);
            checks++;
            if (app.init_calib_complete !== exp) begin
                errors++;
                $display("FAIL calib_cycle %0d: init_calib_complete=%b, required %b", i, app.init_calib_complete, exp);
            end
        end
`ifndef MIG_RESPONDER_BACKPRESSURE_EN
        checks++;
        if (app.app_rdy !== 1'b1) begin
            errors++;
            $display("FAIL calib_app_rdy: app_rdy=%b, required 1", app.app_rdy);
        end
`endif
        $display("reset calibration done");
    endtask

    task automatic test_write_read();
        for (int b = 0; b < BL; b++) begin
            wr_data[b] = {{15{8'hA5}}, 8'(b)};
            wr_mask[b] = '0;
        end
        write_burst(AS'(32'h10), -1);
        read_burst(AS'(32'h10));
    endtask

    task automatic test_byte_mask();
        for (int b = 0; b < BL; b++) begin
            wr_data[b] = '1;
            wr_mask[b] = '0;
        end
        write_burst(AS'(32'h40), -1);
        for (int b = 0; b < BL; b++) begin
            wr_data[b] = '0;
            wr_mask[b] = 16'hFFFE;
        end
        write_burst(AS'(32'h40), -1);
        read_burst(AS'(32'h40));
    endtask

    task automatic test_protocol_errors();
        bit ok;
        int seen;
        checks++;
        if (app.protocol_error !== 1'b0) begin
            errors++;
            $display("FAIL perr_initial: protocol_error=%b, required 0", app.protocol_error);
        end
        issue_cmd(AS'(32'h80), 3'b111, ok);
        seen = 0;
        for (int i = 0; i < RL + BL + 2; i++) begin
            if (app.app_rd_data_valid === 1'b1) seen++;
            step();
        end
        checks++;
        if (app.protocol_error !== 1'b1) begin
            errors++;
            $display("FAIL perr_illegal_cmd: protocol_error=%b, required 1", app.protocol_error);
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL illegal_cmd_beats: saw %0d data beats, required 0", seen);
        end
        $display("illegal cmd 111 issued");

        do_reset();
        checks++;
        if (app.protocol_error !== 1'b0) begin
            errors++;
            $display("FAIL perr_cleared: protocol_error=%b after reset, required 0", app.protocol_error);
        end
        app.app_wdf_wren = 1'b1;
        step();
        app.app_wdf_wren = 1'b0;
        checks++;
        if (app.protocol_error !== 1'b1) begin
            errors++;
            $display("FAIL perr_stray_wren: protocol_error=%b, required 1", app.protocol_error);
        end
        $display("stray wdf_wren in idle");

        do_reset();
        for (int b = 0; b < BL; b++) begin
            wr_data[b] = {$urandom, $urandom, $urandom, $urandom};
            wr_mask[b] = '0;
        end
        write_burst(AS'(32'h100), 3);
        checks++;
        if (app.protocol_error !== 1'b1) begin
            errors++;
            $display("FAIL perr_early_end: protocol_error=%b, required 1", app.protocol_error);
        end
        read_burst(AS'(32'h100));
    endtask

    task automatic test_reset_mid_read();
        bit ok;
        int seen;
        int n;
        issue_cmd(AS'(32'h10), 3'b001, ok);
        seen = 0;
        n    = 0;
        while (ok && seen < 3 && n < TIMEOUT) begin
            if (app.app_rd_data_valid === 1'b1) seen++;
            if (seen < 3) begin
                step();
                n++;
            end
        end
        checks++;
        if (seen != 3) begin
            errors++;
            $display("FAIL mid_read_beats: saw %0d beats before reset point, required 3", seen);
        end
        rst_n = 1'b0;
        step();
        checks++;
        if (app.app_rd_data_valid !== 1'b0 || app.init_calib_complete !== 1'b0 || app.app_rdy !== 1'b0) begin
            errors++;
            $display("FAIL mid_read_reset: valid=%b init=%b app_rdy=%b, required 0 0 0",
                     app.app_rd_data_valid, app.init_calib_complete, app.app_rdy);
        end
        $display("reset asserted during read beat 2");
        do_reset();
        read_burst(AS'(32'h10));
    endtask

    task automatic test_random();
        logic [AS-1:0] addr;
        for (int s = 0; s < NBURST; s++) begin
            addr = AS'($urandom);
            addr[3 +: 7] = 7'(s);
            for (int b = 0; b < BL; b++) begin
                wr_data[b] = {$urandom, $urandom, $urandom, $urandom};
                wr_mask[b] = '0;
            end
            write_burst(addr, -1);
        end
        for (int t = 0; t < 100; t++) begin
            addr = AS'($urandom);
            if ($urandom_range(0, 1) == 0) begin
                for (int b = 0; b < BL; b++) begin
                    wr_data[b] = {$urandom, $urandom, $urandom, $urandom};
                    wr_mask[b] = 16'($urandom);
                end
                write_burst(addr, -1);
            end else begin
                read_burst(addr);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_read();
        test_byte_mask();
        test_protocol_errors();
        test_reset_mid_read();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
